assoc_cache_ctrl: RTL

- Parametrised N-way set-associative cache controller; successor to the direct-mapped 24-bit cache used in the processor trace benches.
- Processor side: valid/ready request handshake; backing side: single-word memory port with ack handshake.
- Policy: write-through, write-allocate, one word per line, true-LRU replacement.
- Built-in saturating hit/miss counters replace bench-side miss counting.

---
 rtl/assoc_cache_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative, write-through / write-allocate cache controller with
// true-LRU replacement, single-word backing-memory port and saturating hit/miss counters.
module assoc_cache_ctrl #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 24,
  parameter int INDEX_W = 4,
  parameter int WAYS    = 2,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_data,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              clear_stats,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MEM, S_RESP} state_t;

  state_t              r_state;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic                r_resp_hit;
  logic [DATA_W-1:0]   r_resp_data;
  logic                r_mem_valid;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [CNT_W-1:0]    r_hit_cnt;
  logic [CNT_W-1:0]    r_miss_cnt;

  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [AGE_W-1:0]    r_way;

  logic [WAYS-1:0]     r_valid [SETS];
  logic [AGE_W-1:0]    r_age   [SETS][WAYS];
  logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
  logic [DATA_W-1:0]   r_data  [SETS][WAYS];

  logic                w_accept;
  logic [INDEX_W-1:0]  w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [WAYS-1:0]     w_hit_vec;
  logic                w_hit;
  logic [AGE_W-1:0]    w_hit_way;
  logic                w_inv_found;
  logic [AGE_W-1:0]    w_inv_way;
  logic [AGE_W-1:0]    w_lru_way;
  logic [AGE_W-1:0]    w_way;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Ages younger than the touched way's age move one step older; touched way becomes 0.
  function automatic logic [AGE_W-1:0] lru_age(input logic [AGE_W-1:0] cur,
                                               input logic [AGE_W-1:0] used_age,
                                               input logic             is_used);
    if (is_used) return '0;
    if (cur < used_age) return cur + AGE_W'(1);
    return cur;
  endfunction

  assign w_accept = req_valid && r_req_ready;
  assign w_idx    = r_addr[INDEX_W-1:0];
  assign w_tag    = r_addr[ADDR_W-1:INDEX_W];
  assign w_hit    = |w_hit_vec;

  always_comb begin
    w_hit_vec   = '0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    w_lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag);
      if (w_hit_vec[w]) w_hit_way = AGE_W'(w);
      if (r_age[w_idx][w] == AGE_W'(WAYS-1)) w_lru_way = AGE_W'(w);
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = AGE_W'(w);
      end
    end
    w_way = w_hit ? w_hit_way : (w_inv_found ? w_inv_way : w_lru_way);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_data  <= '0;
      r_mem_valid  <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_way        <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_age[s][w] <= AGE_W'(w);
      end
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_state     <= S_LOOKUP;
          end
        end
        // Lookup stage: tag compare, counters, write-allocate and hit-path LRU update
        S_LOOKUP: begin
          r_way      <= w_way;
          r_resp_hit <= w_hit;
          r_resp_data <= r_we ? r_wdata : r_data[w_idx][w_hit_way];
          if (r_we || w_hit) begin
            for (int w = 0; w < WAYS; w++)
              r_age[w_idx][w] <= lru_age(r_age[w_idx][w], r_age[w_idx][w_way], AGE_W'(w) == w_way);
          end
          if (r_we) r_valid[w_idx][w_way] <= 1'b1;
          if (!r_we && w_hit) begin
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_mem_valid <= 1'b1;
            r_mem_we    <= r_we;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= r_wdata;
            r_state     <= S_MEM;
          end
        end
        // Memory stage: hold the request until ack; read misses fill the victim here
        S_MEM: begin
          if (mem_ack) begin
            r_mem_valid  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
            if (!r_we) begin
              r_resp_data            <= mem_rdata;
              r_valid[w_idx][r_way]  <= 1'b1;
              for (int w = 0; w < WAYS; w++)
                r_age[w_idx][w] <= lru_age(r_age[w_idx][w], r_age[w_idx][r_way], AGE_W'(w) == r_way);
            end
          end
        end
        default: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase

      if (clear_stats) begin
        r_hit_cnt  <= '0;
        r_miss_cnt <= '0;
      end else if (r_state == S_LOOKUP) begin
        if (w_hit) r_hit_cnt  <= sat_inc(r_hit_cnt);
        else       r_miss_cnt <= sat_inc(r_miss_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
    if (r_state == S_LOOKUP && r_we) begin
      r_tag[w_idx][w_way]  <= w_tag;
      r_data[w_idx][w_way] <= r_wdata;
    end
    if (r_state == S_MEM && mem_ack && !r_we) begin
      r_tag[w_idx][r_way]  <= w_tag;
      r_data[w_idx][r_way] <= mem_rdata;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_hit   = r_resp_hit;
  assign resp_data  = r_resp_data;
  assign mem_valid  = r_mem_valid;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

endmodule
